// File: rtl/image_ram_pkg.sv
// Shared constants and FSM state type for the image RAM arbiter.
package image_ram_pkg;

    localparam int unsigned IMG_W      = 300;
    localparam int unsigned IMG_H      = 300;
    localparam int unsigned IMG_PIXELS = IMG_W * IMG_H;
    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_CPU_ACK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/image_ram_arbiter.sv
// Single-port image RAM arbiter between a free-running VGA reader and a CPU.
// Define ARB_STARVE_GUARD_EN to let a starved CPU override the VGA after MAX_WAIT cycles.
module image_ram_arbiter #(
    parameter int unsigned IMG_PIXELS = image_ram_pkg::IMG_PIXELS,
    parameter int unsigned ADDR_W     = image_ram_pkg::ADDR_W,
`ifdef ARB_STARVE_GUARD_EN
    parameter int unsigned DATA_W     = image_ram_pkg::DATA_W,
    parameter int unsigned MAX_WAIT   = 15
`else
    parameter int unsigned DATA_W     = image_ram_pkg::DATA_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_STARVE_GUARD_EN
    ,
    output logic              vga_miss
`endif
);

    import image_ram_pkg::*;

    arb_state_t        r_state;
    logic              r_vga_valid;
    logic              r_vga_oob;
    logic              r_cpu_ack;
    logic              r_cpu_err;
    logic              r_cpu_rd;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic              w_cpu_elig;
    logic              w_cpu_gnt;
    logic              w_vga_gnt;
    logic              w_cpu_oob;
    logic              w_vga_oob;
    logic [DATA_W-1:0] w_cpu_rd_val;

    assign w_cpu_oob  = 32'(cpu_addr) >= IMG_PIXELS;
    assign w_vga_oob  = 32'(vga_addr) >= IMG_PIXELS;
    // No grants while reset is held so the RAM sees no stray writes.
    assign w_cpu_elig = !rst && (r_state == ARB_IDLE) && cpu_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_vga_miss;
    logic              w_starved;

    assign w_starved = w_cpu_elig && (r_wait_cnt == WAIT_W'(MAX_WAIT));
    assign w_cpu_gnt = w_cpu_elig && (!vga_req || w_starved);
    assign vga_miss  = r_vga_miss;

    // Starvation counter and sticky record of VGA requests lost to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_vga_miss <= 1'b0;
        end else begin
            if (w_cpu_gnt) begin
                r_wait_cnt <= '0;
            end else if (w_cpu_elig) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_cpu_gnt && vga_req) begin
                r_vga_miss <= 1'b1;
            end
        end
    end
`else
    assign w_cpu_gnt = w_cpu_elig && !vga_req;
`endif

    assign w_vga_gnt = !rst && vga_req && !w_cpu_gnt;

    // RAM port mux: winner drives, idle port parks at address 0.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (w_cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we && !w_cpu_oob;
            ram_wdata = cpu_wdata;
        end else if (w_vga_gnt) begin
            ram_addr  = vga_addr;
        end
    end

    // FSM plus the registered response flags for both ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_vga_valid <= 1'b0;
            r_vga_oob   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rd    <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_vga_valid <= w_vga_gnt;
            r_vga_oob   <= w_vga_oob;
            r_cpu_ack   <= w_cpu_gnt;
            r_cpu_err   <= w_cpu_gnt && w_cpu_oob;
            r_cpu_rd    <= w_cpu_gnt && !cpu_we;
            if (r_cpu_ack && r_cpu_rd) begin
                r_cpu_rdata <= w_cpu_rd_val;
            end
            case (r_state)
                ARB_IDLE:    if (w_cpu_gnt) r_state <= ARB_CPU_ACK;
                ARB_CPU_ACK: r_state <= ARB_IDLE;
                default:     r_state <= ARB_IDLE;
            endcase
        end
    end

    // RAM data arrives the cycle after grant, so read data is steered, not re-registered.
    assign w_cpu_rd_val = r_cpu_err ? '0 : ram_rdata;
    assign cpu_rdata    = (r_cpu_ack && r_cpu_rd) ? w_cpu_rd_val : r_cpu_rdata;
    assign cpu_ack      = r_cpu_ack;
    assign cpu_err      = r_cpu_err;
    assign vga_valid    = r_vga_valid;
    assign vga_data     = (r_vga_valid && !r_vga_oob) ? ram_rdata : '0;

endmodule
